// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a tx_start/busy launch handshake.
// Define UART_TX_FIFO_OVERRUN_CNT_EN to add a saturating dropped-write counter port.
module uart_tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overrun,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_busy
`ifdef UART_TX_FIFO_OVERRUN_CNT_EN
  ,
  output logic [7:0]            overrun_cnt
`endif
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              mem_q [DEPTH];
  logic [7:0]              mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    overrun_q, overrun_d;
  logic                    tx_start_q, tx_start_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    push, launch;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overrun  = overrun_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

  always_comb begin
    push       = wr_en && !full;
    launch     = (state_q == IDLE) && !empty && !tx_busy;
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tx_data_d  = tx_data_q;
    tx_start_d = launch;
    // full is the pre-edge value, so a write is dropped even when a pop frees a slot this cycle
    overrun_d  = wr_en && full;
    mem_d      = mem_q;

    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + DEPTH_LOG2'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (launch) begin
          tx_data_d = mem_q[rd_ptr_q];
          rd_ptr_d  = rd_ptr_q + DEPTH_LOG2'(1);
          state_d   = WAIT_BUSY;
        end
      end
      WAIT_BUSY: if (tx_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    if (push && !launch)      count_d = count_q + CNT_W'(1);
    else if (!push && launch) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Storage contents are meaningless after reset, so the array has no reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef UART_TX_FIFO_OVERRUN_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (wr_en && full && (ovf_cnt_q != 8'hFF)) ovf_cnt_d = ovf_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_cnt_q <= '0;
    else        ovf_cnt_q <= ovf_cnt_d;
  end

  assign overrun_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: vector table plus hand sequences with a serial transmitter model.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       full, empty, overrun, tx_start, tx_busy;
  logic [4:0] count;
  logic [7:0] tx_data;
`ifdef UART_TX_FIFO_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt;
`endif

  logic busy_man = 1'b0;
  logic busy_mdl;
  logic mdl_en = 1'b0;
  assign tx_busy = mdl_en ? busy_mdl : busy_man;

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overrun  (overrun),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy)
`ifdef UART_TX_FIFO_OVERRUN_CNT_EN
    ,
    .overrun_cnt (overrun_cnt)
`endif
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_data  = '0;
    busy_man = 1'b0;
    mdl_en   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Transmitter model: 4 clocks per bit, start + 8 data LSB first + stop
  logic [9:0] sh = '1;
  int unsigned bitcnt = 0, clkcnt = 0;
  int n_launch = 0;
  int dup_err = 0;
  logic start_prev = 1'b0;
  logic ser_line;
  assign ser_line = sh[0];

  always @(posedge clk) begin
    start_prev <= tx_start;
    if (tx_start && start_prev) dup_err <= dup_err + 1;
    if (!mdl_en) begin
      busy_mdl <= 1'b0;
      sh       <= '1;
      bitcnt   <= 0;
      clkcnt   <= 0;
    end else if (!busy_mdl) begin
      if (tx_start) begin
        sh       <= {1'b1, tx_data, 1'b0};
        busy_mdl <= 1'b1;
        bitcnt   <= 0;
        clkcnt   <= 0;
        n_launch <= n_launch + 1;
      end
    end else begin
      if (tx_start) dup_err <= dup_err + 1;
      if (clkcnt == 3) begin
        clkcnt <= 0;
        if (bitcnt == 9) busy_mdl <= 1'b0;
        else begin
          sh     <= {1'b1, sh[9:1]};
          bitcnt <= bitcnt + 1;
        end
      end else clkcnt <= clkcnt + 1;
    end
  end

  // Serial receiver sampling mid-bit
  logic [7:0] rx_q[$];
  int stop_err = 0;
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge ser_line);
      repeat (2) @(posedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (4) @(posedge clk);
        b[k] = ser_line;
      end
      repeat (4) @(posedge clk);
      if (ser_line !== 1'b1) stop_err++;
      rx_q.push_back(b);
    end
  end

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       busy;
    logic       st;
    logic [7:0] td;
    logic [4:0] cnt;
    logic       emp;
    logic       ful;
    logic       ov;
  } vec_t;

  function automatic vec_t mk(logic wr, logic [7:0] d, logic busy, logic st, logic [7:0] td,
                              logic [4:0] cnt, logic emp, logic ful, logic ov);
    vec_t v;
    v.wr = wr; v.d = d; v.busy = busy; v.st = st; v.td = td;
    v.cnt = cnt; v.emp = emp; v.ful = ful; v.ov = ov;
    return v;
  endfunction

  vec_t tbl[$];

  task automatic pop_hs(input logic [7:0] exp, input string nm);
    busy_man = 1'b0;
    step();
    chk({nm, " start"}, tx_start, 1'b1);
    chk({nm, " data"}, tx_data, exp);
    busy_man = 1'b1;
    step();
    busy_man = 1'b0;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int cyc;

    // Single byte 0x41, then launch handshake
    tbl.push_back(mk(1, 8'h41, 0,  0, 8'h00, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0,  1, 8'h41, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0,  0, 8'h41, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1,  0, 8'h41, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0,  0, 8'h41, 0, 1, 0, 0));
    // Fill 16 while busy, then 17th dropped
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(1, 8'h50 + 8'(i), 1,  0, 8'h41, 5'(i + 1), 0, (i == 15), 0));
    tbl.push_back(mk(1, 8'h60, 1,  0, 8'h41, 16, 0, 1, 1));
    tbl.push_back(mk(0, 8'h00, 1,  0, 8'h41, 16, 0, 1, 0));
    // Write while full in the same cycle as a pop: still dropped
    tbl.push_back(mk(1, 8'h61, 0,  1, 8'h50, 15, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0,  0, 8'h50, 15, 0, 0, 0));

    do_reset();
    chk("rst tx_start", tx_start, 1'b0);
    chk("rst tx_data", tx_data, 8'h00);
    chk("rst overrun", overrun, 1'b0);
    chk("rst count", count, 5'd0);
    chk("rst empty", empty, 1'b1);
    chk("rst full", full, 1'b0);
`ifdef UART_TX_FIFO_OVERRUN_CNT_EN
    chk("rst overrun_cnt", overrun_cnt, 8'd0);
`endif

    foreach (tbl[i]) begin
      wr_en    = tbl[i].wr;
      wr_data  = tbl[i].d;
      busy_man = tbl[i].busy;
      step();
      chk($sformatf("v%0d tx_start", i), tx_start, tbl[i].st);
      chk($sformatf("v%0d tx_data", i), tx_data, tbl[i].td);
      chk($sformatf("v%0d count", i), count, tbl[i].cnt);
      chk($sformatf("v%0d empty", i), empty, tbl[i].emp);
      chk($sformatf("v%0d full", i), full, tbl[i].ful);
      chk($sformatf("v%0d overrun", i), overrun, tbl[i].ov);
    end
`ifdef UART_TX_FIFO_OVERRUN_CNT_EN
    chk("overrun_cnt after two drops", overrun_cnt, 8'd2);
`endif

    // Burst of 16 through the serial model
    do_reset();
    busy_man = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i);
      step();
    end
    wr_en = 1'b0;
    chk("burst full", full, 1'b1);
    chk("burst count", count, 5'd16);
    mdl_en = 1'b1;
    cyc = 0;
    while (rx_q.size() < 16 && cyc < 3000) begin
      step();
      cyc++;
    end
    chk("burst rx bytes", rx_q.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < rx_q.size()) chk($sformatf("burst rx[%0d]", i), rx_q[i], 8'(i));
    repeat (6) step();
    chk("burst launches", n_launch, 16);
    chk("burst stop bits", stop_err, 0);
    chk("burst empty", empty, 1'b1);
    mdl_en = 1'b0;

    // tx_busy held high for 20 cycles with bytes queued
    do_reset();
    wr_en = 1'b1; wr_data = 8'h31; step();
    chk("hold count0", count, 5'd1);
    wr_data = 8'h32; step();
    chk("hold launch1", tx_start, 1'b1);
    chk("hold data1", tx_data, 8'h31);
    chk("hold count1", count, 5'd1);
    wr_data = 8'h33; busy_man = 1'b1; step();
    chk("hold count2", count, 5'd2);
    wr_en = 1'b0;
    hi = 0;
    for (int i = 0; i < 19; i++) begin
      step();
      if (tx_start !== 1'b0) hi++;
    end
    chk("hold no launch while busy", hi, 0);
    busy_man = 1'b0; step();
    chk("hold idle cycle", tx_start, 1'b0);
    step();
    chk("hold launch2", tx_start, 1'b1);
    chk("hold data2", tx_data, 8'h32);
    chk("hold count3", count, 5'd1);

    // Simultaneous push and pop at count 5 across pointer wrap
    do_reset();
    busy_man = 1'b1;
    for (int i = 0; i < 15; i++) begin
      wr_en = 1'b1; wr_data = 8'hA0 + 8'(i); step();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 10; i++) pop_hs(8'hA0 + 8'(i), $sformatf("wrap pop%0d", i));
    chk("wrap count before", count, 5'd5);
    wr_en = 1'b1; wr_data = 8'hC0; busy_man = 1'b0; step();
    chk("wrap simul start", tx_start, 1'b1);
    chk("wrap simul data", tx_data, 8'hAA);
    chk("wrap simul count", count, 5'd5);
    wr_data = 8'hC1; busy_man = 1'b1; step();
    wr_en = 1'b0;
    chk("wrap count6", count, 5'd6);
    busy_man = 1'b0; step();
    pop_hs(8'hAB, "wrap tail0");
    pop_hs(8'hAC, "wrap tail1");
    pop_hs(8'hAD, "wrap tail2");
    pop_hs(8'hAE, "wrap tail3");
    pop_hs(8'hC0, "wrap tail4");
    pop_hs(8'hC1, "wrap tail5");
    chk("wrap empty", empty, 1'b1);

    // Reset asserted while tx_start is high drops it without a clock edge
    do_reset();
    wr_en = 1'b1; wr_data = 8'h55; step();
    wr_en = 1'b0; step();
    chk("async pre start", tx_start, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async tx_start", tx_start, 1'b0);
    chk("async tx_data", tx_data, 8'h00);

    // Reset in WAIT_DONE with 4 bytes queued
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'h70 + 8'(i);
      if (i >= 2) busy_man = 1'b1;
      step();
    end
    wr_en = 1'b0;
    chk("rstwd count before", count, 5'd4);
    #3 rst_n = 1'b0;
    #1;
    chk("rstwd count", count, 5'd0);
    chk("rstwd empty", empty, 1'b1);
    chk("rstwd tx_start", tx_start, 1'b0);
    step();
    busy_man = 1'b0;
    rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tx_start !== 1'b0) hi++;
    end
    chk("rstwd no launch after", hi, 0);
    chk("rstwd empty after", empty, 1'b1);
    chk("no back-to-back tx_start", dup_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
